// File: rtl/wr_burst_ctrl.sv
// Write-domain burst controller: pulls a counted burst from a producer
// through a 2-entry skid buffer and writes it into the FIFO.
module wr_burst_ctrl #(
  parameter int DATASIZE = 8,
  parameter int LENW     = 8,
  parameter int CNTW     = 16
) (
  input  logic                wclk,
  input  logic                w_rst_n,
  input  logic                burst_start,
  input  logic [LENW-1:0]     burst_len,
  input  logic                s_valid,
  input  logic [DATASIZE-1:0] s_data,
  output logic                s_ready,
  input  logic                wfull,
  output logic                winc,
  output logic [DATASIZE-1:0] wdata,
  output logic                busy,
  output logic                burst_done,
  output logic [CNTW-1:0]     words_total
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [LENW-1:0]     acc_rem;
  logic [LENW-1:0]     wr_rem;
  logic [1:0]          occ;
  logic [DATASIZE-1:0] buf0;
  logic [DATASIZE-1:0] buf1;
  logic [CNTW-1:0]     cnt;
  logic                in_run;
  logic                acc;
  logic                wr;
  logic                start;

  assign in_run      = (state == RUN);
  assign start       = (state == IDLE) && burst_start;
  assign s_ready     = in_run && !occ[1] && (acc_rem != '0);
  assign winc        = in_run && (occ != 2'd0) && !wfull;
  assign acc         = s_valid && s_ready;
  assign wr          = winc;
  assign wdata       = buf0;
  assign busy        = (state == RUN) || (state == DONE);
  assign burst_done  = (state == DONE);
  assign words_total = cnt;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (burst_start) begin
          if (burst_len == '0) state_nx = DONE;
          else                 state_nx = RUN;
        end
      end
      RUN: begin
        if (wr && (wr_rem == LENW'(1))) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wclk or negedge w_rst_n) begin
    if (!w_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge wclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      acc_rem <= '0;
      wr_rem  <= '0;
    end else if (start) begin
      acc_rem <= burst_len;
      wr_rem  <= burst_len;
    end else begin
      if (acc) acc_rem <= acc_rem - LENW'(1);
      if (wr)  wr_rem  <= wr_rem - LENW'(1);
    end
  end

  // accept+write together only happens with exactly one entry held
  always_ff @(posedge wclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      occ  <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      unique case ({acc, wr})
        2'b10: begin
          if (occ == 2'd0) buf0 <= s_data;
          else             buf1 <= s_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: buf0 <= s_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge wclk or negedge w_rst_n) begin
    if (!w_rst_n)  cnt <= '0;
    else if (wr)   cnt <= cnt + CNTW'(1);
  end

endmodule

// File: tb/tb_wr_burst_ctrl.sv
// Randomized scoreboard bench for wr_burst_ctrl: expected words queued
// at burst start, popped and compared by an independent write monitor.
module tb_wr_burst_ctrl;

  logic        wclk;
  logic        w_rst_n;
  logic        burst_start;
  logic [7:0]  burst_len;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;
  logic        busy;
  logic        burst_done;
  logic [15:0] words_total;

  int          checks;
  int          errors;
  int          cyc;
  logic [7:0]  exp_q[$];
  logic [15:0] model_total;

  wr_burst_ctrl #(
    .DATASIZE(8),
    .LENW(8),
    .CNTW(16)
  ) dut (
    .wclk(wclk),
    .w_rst_n(w_rst_n),
    .burst_start(burst_start),
    .burst_len(burst_len),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .wfull(wfull),
    .winc(winc),
    .wdata(wdata),
    .busy(busy),
    .burst_done(burst_done),
    .words_total(words_total)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  initial cyc = 0;
  always @(posedge wclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t",
               name, act, exp, $time);
    end
  endtask

  // write monitor: every FIFO write must match the next expected word
  initial begin
    forever begin
      @(negedge wclk);
      if (w_rst_n && winc) begin
        chk("winc_while_full", wfull, 1'b0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          chk("wdata", wdata, exp_q.pop_front());
        end
        chk("total_at_write", words_total, model_total);
        model_total = model_total + 16'd1;
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_s_ready"}, s_ready, 0);
    chk({tag, "_winc"}, winc, 0);
    chk({tag, "_wdata"}, wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, burst_done, 0);
    chk({tag, "_total"}, words_total, 0);
  endtask

  task automatic do_reset();
    @(posedge wclk);
    #3 w_rst_n = 1'b0;
    #1 chk_zero("async_rst");
    exp_q.delete();
    model_total = '0;
    burst_start = 1'b0;
    s_valid = 1'b0;
    wfull = 1'b0;
    @(posedge wclk);
    #1 w_rst_n = 1'b1;
  endtask

  // mode 0 stream, 1 wfull in cycles 3..7, 2 valid toggling, 3 random
  task automatic run_burst(input int len, input int mode, input bit ign,
                           input int base);
    logic [7:0] words[$];
    int acc, wr, pi, r, t_start, first, last, done_r, lim;
    bit done, hs;
    for (int i = 0; i < len + 4; i++) begin
      if (base >= 0) words.push_back(8'(base + i));
      else           words.push_back(8'($urandom));
    end
    @(posedge wclk);
    #1;
    burst_start = 1'b1;
    burst_len = 8'(len);
    for (int i = 0; i < len; i++) exp_q.push_back(words[i]);
    @(posedge wclk);
    #1;
    t_start = cyc;
    burst_start = 1'b0;
    acc = 0; wr = 0; pi = 0; done = 0;
    first = -1; last = -1; done_r = -1;
    lim = 4 * len + 40;
    for (int k = 0; k < lim && !done; k++) begin
      r = cyc - t_start + 1;
      case (mode)
        1:       wfull = (r >= 3) && (r <= 7);
        3:       wfull = ($urandom_range(0, 2) == 0);
        default: wfull = 1'b0;
      endcase
      case (mode)
        2:       s_valid = r[0];
        3:       s_valid = ($urandom_range(0, 3) != 0);
        default: s_valid = 1'b1;
      endcase
      s_data = (pi < words.size()) ? words[pi] : 8'h00;
      if (ign && r == 2) begin
        burst_start = 1'b1;
        burst_len = 8'd7;
      end else begin
        burst_start = 1'b0;
      end
      @(negedge wclk);
      chk("busy", busy, 1);
      chk("s_ready", s_ready, 32'((acc - wr < 2) && (acc < len)));
      chk("winc", winc, 32'((acc - wr > 0) && !wfull));
      if (winc) begin
        if (first < 0) first = r;
        last = r;
        wr++;
      end
      hs = s_valid && s_ready;
      if (burst_done) begin
        done = 1;
        done_r = r;
      end
      @(posedge wclk);
      #1;
      if (hs) begin
        acc++;
        pi++;
      end
    end
    if (!done) chk("timeout_no_done", 0, 1);
    burst_start = 1'b0;
    s_valid = 1'b0;
    wfull = 1'b0;
    chk("accepted", acc, len);
    chk("written", wr, len);
    chk("queue_empty", exp_q.size(), 0);
    if (mode == 0) begin
      if (len == 0) begin
        chk("zero_done_cycle", done_r, 1);
        chk("zero_no_winc", first, -1);
      end else begin
        chk("first_winc_cycle", first, 2);
        chk("last_winc_cycle", last, len + 1);
        chk("done_cycle", done_r, len + 2);
      end
    end
    chk("total_after", words_total, model_total);
    @(negedge wclk);
    chk("idle_busy", busy, 0);
    chk("idle_done", burst_done, 0);
    chk("idle_s_ready", s_ready, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_total = '0;
    w_rst_n = 1'b0;
    burst_start = 1'b0;
    burst_len = '0;
    s_valid = 1'b0;
    s_data = '0;
    wfull = 1'b0;
    #13 chk_zero("por");
    @(posedge wclk);
    #1 w_rst_n = 1'b1;

    // abort a burst in flight with an async reset
    @(posedge wclk);
    #1;
    burst_start = 1'b1;
    burst_len = 8'd5;
    s_valid = 1'b1;
    s_data = 8'h55;
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h55);
    @(posedge wclk);
    #1 burst_start = 1'b0;
    repeat (3) @(posedge wclk);
    do_reset();
    run_burst(3, 0, 0, 8'h30);

    run_burst(4, 0, 0, 8'hA0);
    chk("stream_total", words_total, 7);
    run_burst(6, 1, 0, -1);
    run_burst(5, 2, 0, -1);
    run_burst(0, 0, 0, -1);
    run_burst(5, 0, 1, 8'h10);
    repeat (20) run_burst($urandom_range(0, 12), 3, $urandom_range(0, 1), -1);

    do_reset();
    repeat (257) run_burst(255, 0, 0, -1);
    chk("pre_wrap", words_total, 16'hFFFF);
    run_burst(2, 0, 0, -1);
    chk("post_wrap", words_total, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
